sprite_list_reader: RTL and testbench
=====================================

// Module: sprite_list_reader
// PURPOSE
//   Read-side client for one port of a dual-port RAM: on a start pulse it sweeps
//   NUM_REC fixed-size records out of the RAM and presents each one, whole, on a
//   valid/ready stream.
//   The typical use is the video side fetching sprite attributes during vblank.
//   The CPU writes that RAM through the other port.
//   Drives the RAM port's enable and address and consumes its registered,
//   1-cycle-latency q. Never writes the RAM.
// PARAMETERS
//   ADDR_W     8      RAM address width; address arithmetic wraps mod 2**ADDR_W
//   DATA_W     8      RAM word width
//   REC_BYTES  4      RAM words per record (>=1)
//   NUM_REC    24     records per sweep (>=1)
//   BASE       0      RAM address of record 0, word 0
// PORTS
//   clock        in   1                  single clock; all logic on its rising edge
//   reset_n      in   1                  asynchronous, active-low reset
//   start        in   1                  begin a sweep; sampled only in IDLE
//   abort        in   1                  terminate sweep; back to IDLE, no done
//   busy         out  1                  high while a sweep is in progress
//   done         out  1                  1-cycle pulse, sweep finished normally
//   ram_enable   out  1                  RAM port enable (registered)
//   ram_address  out  ADDR_W             RAM port address (registered)
//   ram_q        in   DATA_W             RAM read data, valid 1 cycle after enable
//   rec_valid    out  1                  rec_data/rec_index hold a complete record
//   rec_ready    in   1                  consumer accepts the record when valid&ready
//   rec_data     out  REC_BYTES*DATA_W   word k in bits [k*DATA_W +: DATA_W]
//   rec_index    out  $clog2(NUM_REC)    record number, 0..NUM_REC-1
// BEHAVIOUR
//   Reset: all outputs 0 (busy, done, ram_enable, ram_address, rec_*); state IDLE.
//     Reset applied mid-sweep abandons the sweep at once; no done pulse.
//   States: IDLE -> FETCH -> PRESENT -> (FETCH | FINISH) -> IDLE.
//   IDLE: start=1 at edge E0 -> FETCH, busy=1, ram_enable=1, ram_address=BASE.
//     start in any other state is ignored.
//   FETCH: one word address is issued per cycle, for REC_BYTES cycles.
//     Address = BASE + rec*REC_BYTES + k (mod 2**ADDR_W).
//     Word k is captured from ram_q on the edge after the RAM registers it, i.e.
//     2 edges after it is issued.
//     ram_enable drops after the last issue.
//     Record 0 becomes valid REC_BYTES+1 cycles after E0; rec_valid rises
//     together with entry to PRESENT.
//   PRESENT: rec_valid=1; rec_data and rec_index stay stable until the handshake.
//     Handshake (valid & ready) at edge H: rec_valid=0 at H.
//     If records remain: FETCH of the next record starts at H, and it becomes
//     valid at H+REC_BYTES+1. No prefetch overlap.
//     If it was the last record (index NUM_REC-1): FINISH.
//   FINISH: done=1 for exactly one cycle; busy=0 in the same cycle; -> IDLE.
//   abort=1 in any non-IDLE state has priority over every other event:
//     - next edge: IDLE; busy, rec_valid, ram_enable = 0; done not pulsed.
//     - words still in flight from the RAM are discarded.
//   start and abort in the same IDLE cycle: abort wins; remain IDLE.
//   A new start is accepted in the cycle after done.
//   rec_ready while rec_valid=0 has no effect.
// CONFIGURATION
//   SPRITE_LIST_SKIP_EMPTY_EN defined:
//     - a record whose word 0 == 0 is never presented.
//     - the reader moves straight from FETCH to the next record's FETCH, or to
//       FINISH if it was the last record.
//     - rec_index of presented records is still their true record number.
//     - a sweep in which every record is empty ends with done REC_BYTES+2 cycles
//       after the last record's first issue, with no rec_valid.
//   Not defined: every record is presented, whatever its contents.
// TESTING  (REC_BYTES=4, NUM_REC=3, BASE=8'h10, DATA_W=8, RAM word[a]=a)
//   1 Reset asserted mid-FETCH -> all outputs 0 immediately (async); after
//     release, idle until start.
//   2 start pulse, rec_ready tied 1:
//     - ram_address runs 10,11,12,13 starting the cycle after start.
//     - rec0 valid 5 cycles after start with rec_data=32'h13121110, index 0.
//     - rec1=32'h17161514, rec2=32'h1B1A1918.
//     - done pulses once; busy falls with done.
//   3 Hold rec_ready=0 for 10 cycles on rec1:
//     - rec_valid, rec_data and rec_index stay stable.
//     - ram_enable=0 throughout the stall.
//     - sweep completes after rec_ready=1.
//   4 BASE=8'hFE: addresses issued FE,FF,00,01 (wrap);
//     rec0 = 32'h0100FFFE.
//   5 abort during rec1 PRESENT -> IDLE next cycle; no done; a following start
//     resweeps from rec0.
//   6 With SPRITE_LIST_SKIP_EMPTY_EN: word[8'h14]=0 -> only rec0 and rec2 are
//     presented (index 0, 2); done follows rec2.
//     Same stimulus without the macro -> rec1 presented with rec_data=32'h17161500.

Source files
------------

// File: rtl/sprite_list_reader.sv
`default_nettype none
// ============================================================================
// sprite_list_reader: sweeps NUM_REC records of REC_BYTES words out of a RAM
// read port and presents each whole record on a valid/ready stream.
// Optional feature macro: SPRITE_LIST_SKIP_EMPTY_EN (drop records whose word 0 is 0).
// Rev 1.0
// ============================================================================
module sprite_list_reader #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter int                REC_BYTES = 4,
  parameter int                NUM_REC   = 24,
  parameter logic [ADDR_W-1:0] BASE      = '0,
  localparam int               IDX_W     = (NUM_REC > 1) ? $clog2(NUM_REC) : 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          ram_enable,
  output logic [ADDR_W-1:0]             ram_address,
  input  logic [DATA_W-1:0]             ram_q,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [REC_BYTES*DATA_W-1:0]   rec_data,
  output logic [IDX_W-1:0]              rec_index
);

  localparam int               K_W      = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;
  localparam int               REC_W    = REC_BYTES * DATA_W;
  localparam logic [K_W-1:0]   LAST_K   = K_W'(REC_BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REC - 1);

`ifdef SPRITE_LIST_SKIP_EMPTY_EN
  localparam bit SKIP_EMPTY = 1'b1;
`else
  localparam bit SKIP_EMPTY = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_PRESENT = 3'd2,
    S_DRAIN   = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ram_enable_q, ram_enable_d;
  logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
  logic [K_W-1:0]      issue_k_q, issue_k_d;
  logic                cap_vld_q, cap_vld_d;
  logic [K_W-1:0]      cap_k_q, cap_k_d;
  logic                rec_valid_q, rec_valid_d;
  logic [REC_W-1:0]    rec_data_q, rec_data_d;
  logic [IDX_W-1:0]    rec_index_q, rec_index_d;

  logic                w_rec_done;
  logic                w_last;
  logic [DATA_W-1:0]   w_word0;
  logic                w_empty;

  // cap_vld_q/cap_k_q: the RAM latched word cap_k_q on the last edge, so ram_q holds it now
  assign w_rec_done = cap_vld_q && (cap_k_q == LAST_K);
  assign w_last     = (rec_index_q == LAST_IDX);
  assign w_word0    = (cap_k_q == '0) ? ram_q : rec_data_q[DATA_W-1:0];
  assign w_empty    = SKIP_EMPTY && (w_word0 == '0);

  always_comb begin
    logic next_rec;
    next_rec      = 1'b0;
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    ram_enable_d  = 1'b0;
    ram_address_d = ram_address_q;
    issue_k_d     = issue_k_q;
    cap_vld_d     = ram_enable_q;
    cap_k_d       = ram_enable_q ? issue_k_q : cap_k_q;
    rec_valid_d   = rec_valid_q;
    rec_data_d    = rec_data_q;
    rec_index_d   = rec_index_q;

    if (cap_vld_q) begin
      rec_data_d[int'(cap_k_q)*DATA_W +: DATA_W] = ram_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d       = S_FETCH;
          busy_d        = 1'b1;
          ram_enable_d  = 1'b1;
          ram_address_d = BASE;
          issue_k_d     = '0;
          rec_index_d   = '0;
        end
      end
      S_FETCH: begin
        if (ram_enable_q && (issue_k_q != LAST_K)) begin
          ram_enable_d  = 1'b1;
          ram_address_d = ram_address_q + ADDR_W'(1);
          issue_k_d     = issue_k_q + K_W'(1);
        end
        if (w_rec_done) begin
          if (w_empty) begin
            // Empty record: the final decision is held one cycle before done
            if (w_last) state_d = S_DRAIN;
            else        next_rec = 1'b1;
          end else begin
            state_d     = S_PRESENT;
            rec_valid_d = 1'b1;
          end
        end
      end
      S_PRESENT: begin
        if (rec_ready) begin
          rec_valid_d = 1'b0;
          if (w_last) begin
            state_d = S_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = S_FETCH;
            next_rec = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_FINISH;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Records are contiguous, so the next record starts one past the last issued word
    if (next_rec) begin
      ram_enable_d  = 1'b1;
      ram_address_d = ram_address_q + ADDR_W'(1);
      issue_k_d     = '0;
      rec_index_d   = rec_index_q + IDX_W'(1);
    end

    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      ram_enable_d = 1'b0;
      cap_vld_d    = 1'b0;
      rec_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ram_enable_q  <= 1'b0;
      ram_address_q <= '0;
      issue_k_q     <= '0;
      cap_vld_q     <= 1'b0;
      cap_k_q       <= '0;
      rec_valid_q   <= 1'b0;
      rec_data_q    <= '0;
      rec_index_q   <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ram_enable_q  <= ram_enable_d;
      ram_address_q <= ram_address_d;
      issue_k_q     <= issue_k_d;
      cap_vld_q     <= cap_vld_d;
      cap_k_q       <= cap_k_d;
      rec_valid_q   <= rec_valid_d;
      rec_data_q    <= rec_data_d;
      rec_index_q   <= rec_index_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ram_enable  = ram_enable_q;
  assign ram_address = ram_address_q;
  assign rec_valid   = rec_valid_q;
  assign rec_data    = rec_data_q;
  assign rec_index   = rec_index_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_list_reader.sv
`default_nettype none
// tb_sprite_list_reader: randomized scoreboard bench; expected records and
// addresses are derived from a RAM image, checked by an independent monitor.
module tb_sprite_list_reader;

  localparam int         DATA_W    = 8;
  localparam int         REC_BYTES = 4;
  localparam int         NUM_REC   = 3;
  localparam logic [7:0] BASE      = 8'hFE;
`ifdef SPRITE_LIST_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] data;
  } rec_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        rec_ready = 1'b0;
  logic        busy, done, ram_enable, rec_valid;
  logic [7:0]  ram_address;
  logic [7:0]  ram_q;
  logic [31:0] rec_data;
  logic [1:0]  rec_index;

  logic [7:0]  mem [256];
  rec_t        rec_q [$];
  logic [7:0]  addr_q [$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          exp_done = 0;
  int          ready_mode = 0;
  int          stall_cnt = 0;

  sprite_list_reader #(
    .ADDR_W(8), .DATA_W(DATA_W), .REC_BYTES(REC_BYTES), .NUM_REC(NUM_REC), .BASE(BASE)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .ram_enable(ram_enable), .ram_address(ram_address),
    .ram_q(ram_q), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_data(rec_data), .rec_index(rec_index)
  );

  always #5 clock = ~clock;

  // Registered-output RAM read port
  always @(posedge clock) begin
    if (ram_enable) ram_q <= mem[ram_address];
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    total++;
    bad++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic fill_identity();
    for (int a = 0; a < 256; a++) mem[a] = 8'(a);
  endtask

  task automatic fill_random();
    logic [7:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int r = 0; r < NUM_REC; r++) begin
      a = BASE + 8'(r * REC_BYTES);
      if ($urandom_range(0, 2) == 0) mem[a] = 8'h00;
    end
  endtask

  // Expected traffic of one sweep: record r, word k lives at BASE + r*REC_BYTES + k
  task automatic push_sweep();
    rec_t       e;
    logic [7:0] a;
    for (int r = 0; r < NUM_REC; r++) begin
      e.idx  = 2'(r);
      e.data = '0;
      for (int k = 0; k < REC_BYTES; k++) begin
        a = BASE + 8'(r * REC_BYTES + k);
        e.data[k*DATA_W +: DATA_W] = mem[a];
        addr_q.push_back(a);
      end
      if (!(SKIP && e.data[7:0] == 8'h00)) rec_q.push_back(e);
    end
    exp_done++;
  endtask

  task automatic flush();
    addr_q.delete();
    rec_q.delete();
    exp_done = 0;
  endtask

  task automatic do_start();
    push_sweep();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_start);
    int n;
    n = 0;
    while (1) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (done) break;
      n++;
      if (n >= budget) begin
        fail_now("done_timeout", $sformatf("no done within %0d cycles", budget));
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        flush();
        break;
      end
      if (rand_start) start = ($urandom_range(0, 5) == 0);
    end
  endtask

  task automatic wait_rec1();
    int n;
    n = 0;
    while (!(rec_valid && rec_index == 2'd1)) begin
      @(posedge clock); #1;
      n++;
      if (n > 100) begin
        fail_now("rec1_timeout", "record 1 never became valid");
        break;
      end
    end
  endtask

  task automatic check_zero(input string pre);
    chk({pre, "_busy"}, busy, 0);
    chk({pre, "_done"}, done, 0);
    chk({pre, "_ram_enable"}, ram_enable, 0);
    chk({pre, "_ram_address"}, ram_address, 0);
    chk({pre, "_rec_valid"}, rec_valid, 0);
    chk({pre, "_rec_data"}, rec_data, 0);
    chk({pre, "_rec_index"}, rec_index, 0);
  endtask

  task automatic do_abort(input string pre);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    flush();
    chk({pre, "_busy"}, busy, 0);
    chk({pre, "_rec_valid"}, rec_valid, 0);
    chk({pre, "_ram_enable"}, ram_enable, 0);
  endtask

  // Consumer model
  initial begin
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        0: begin rec_ready = 1'b1; stall_cnt = 0; end
        1: begin
          if (rec_valid && rec_index == 2'd1 && stall_cnt < 10) begin
            rec_ready = 1'b0;
            stall_cnt++;
          end else begin
            rec_ready = 1'b1;
          end
        end
        2: rec_ready = !(rec_valid && rec_index == 2'd1);
        default: rec_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor
  bit          hs;
  bit          prev_valid = 1'b0;
  bit          prev_hs = 1'b0;
  logic [31:0] prev_data;
  logic [1:0]  prev_idx;
  int          fetch_start = -1;
  int          pend_done = -1;
  rec_t        mon_e;

  always @(negedge clock) begin
    if (reset_n) begin
      hs = rec_valid && rec_ready && !abort;
      if (ram_enable) begin
        if (addr_q.size() == 0) fail_now("addr_extra", $sformatf("issued %0h with none expected", ram_address));
        else chk("ram_address", ram_address, addr_q.pop_front());
      end
      if (prev_hs) chk("valid_drop", rec_valid, 0);
      if (rec_valid) begin
        chk("no_prefetch", ram_enable, 0);
        if (prev_valid && !prev_hs) begin
          chk("stall_data", rec_data, prev_data);
          chk("stall_index", rec_index, prev_idx);
        end else if (!prev_valid && !SKIP && fetch_start >= 0) begin
          chk("valid_latency", cyc - fetch_start, REC_BYTES + 1);
        end
      end
      if (hs) begin
        if (rec_q.size() == 0) begin
          fail_now("rec_extra", $sformatf("record idx=%0d data=%0h not expected", rec_index, rec_data));
        end else begin
          mon_e = rec_q.pop_front();
          chk("rec_data", rec_data, mon_e.data);
          chk("rec_index", rec_index, mon_e.idx);
          if (mon_e.idx == 2'(NUM_REC - 1)) pend_done = cyc + 1;
          else                              fetch_start = cyc + 1;
        end
      end
      if (!busy && !done && start && !abort) fetch_start = cyc + 1;
      if (done) begin
        if (exp_done == 0) fail_now("done_extra", "done pulsed with no sweep pending");
        else exp_done--;
        chk("done_busy", busy, 0);
        chk("done_recs_left", rec_q.size(), 0);
        if (!SKIP) chk("done_latency", cyc, pend_done);
      end
      prev_valid = rec_valid;
      prev_hs    = hs;
      prev_data  = rec_data;
      prev_idx   = rec_index;
    end else begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end
  end

  // Stimulus
  initial begin
    fill_identity();
    repeat (3) @(posedge clock);
    #1;
    check_zero("por");
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Reset in the middle of a fetch
    ready_mode = 0;
    do_start();
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    check_zero("async_rst");
    flush();
    repeat (2) @(posedge clock);
    #3;
    reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("idle_after_rst", busy, 0);

    // Plain sweep, then a stall on record 1; each start lands in the cycle after done
    do_start();
    wait_done(200, 1'b0);
    @(posedge clock); #1;
    ready_mode = 1;
    do_start();
    wait_done(200, 1'b0);
    @(posedge clock); #1;

    // Abort while record 1 is presented, then a fresh sweep
    ready_mode = 2;
    do_start();
    wait_rec1();
    do_abort("abort_present");
    repeat (5) @(posedge clock);
    #1;
    ready_mode = 0;
    do_start();
    wait_done(200, 1'b0);
    @(posedge clock); #1;

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_enable", ram_enable, 0);
    repeat (2) @(posedge clock);
    #1;

    // Record 1 has an empty word 0
    fill_identity();
    mem[8'(BASE + 8'd4)] = 8'h00;
    do_start();
    wait_done(200, 1'b0);
    @(posedge clock); #1;

    // Random contents, random consumer, stray starts and occasional aborts
    ready_mode = 3;
    for (int s = 0; s < 12; s++) begin
      fill_random();
      do_start();
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 12)) @(posedge clock);
        #1;
        do_abort("abort_rand");
      end else begin
        wait_done(300, 1'b1);
      end
      @(posedge clock); #1;
    end

    repeat (5) @(posedge clock);
    #1;
    chk("final_recs_left", rec_q.size(), 0);
    chk("final_addrs_left", addr_q.size(), 0);
    chk("final_done_owed", exp_done, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
